// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: hazard requests, redirect
// targets, instruction-memory port and the IF/ID register outputs.
// Ports: slave = fetch stage side, master = pipeline/memory side.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic [2:0]  pcsrc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [25:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  modport slave (
    input  stall, flush, pcsrc, branch_taken, branch_target, jump_target,
           jr_target, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
  );

  modport master (
    output stall, flush, pcsrc, branch_taken, branch_target, jump_target,
           jr_target, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, imem address, IF/ID register.
// Latency: imem_addr is combinational from pc; IF/ID loads one edge after fetch.
// Backpressure: stall freezes all state unless an exception vector is selected.
// Ports: clk, reset (async active-low), bus (fetch_stage_if.slave).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.slave bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] mode_bit;
  logic [31:0] instr_q;
  logic [31:0] pp4_q;
  logic        valid_q;
  logic [15:0] count_q;
  logic        exc;
  logic [31:0] vec;

  // Increment stays inside bits 30:0 so the kernel/user bit never flips.
  assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

  // Redirect targets inherit the current mode bit; only vectors enter kernel.
  assign mode_bit = {pc[31], 31'b0};

  always_comb begin
    next_pc = pc_plus4;
    case (bus.pcsrc)
      3'b001:  if (bus.branch_taken)
                 next_pc = (bus.branch_target & 32'h7FFF_FFFF) | mode_bit;
      3'b010:  next_pc = {pc_plus4[31:28], bus.jump_target, 2'b00};
      3'b011:  next_pc = (bus.jr_target & 32'h7FFF_FFFF) | mode_bit;
      default: next_pc = pc_plus4;
    endcase
  end

  assign exc = (bus.pcsrc == 3'b100) || (bus.pcsrc == 3'b101);
  assign vec = bus.pcsrc[0] ? XADR_VEC : ILLOP_VEC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      instr_q <= 32'h0;
      pp4_q   <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 16'h0;
    end else if (exc) begin
      // Exceptions win over stall; the bubble keeps pc+4 for the return address.
      pc      <= vec;
      instr_q <= 32'h0;
      pp4_q   <= pc_plus4;
      valid_q <= 1'b0;
    end else if (bus.stall) begin
      pc      <= pc;
    end else if (bus.flush) begin
      pc      <= next_pc;
      instr_q <= 32'h0;
      pp4_q   <= pc_plus4;
      valid_q <= 1'b0;
    end else begin
      pc      <= next_pc;
      instr_q <= bus.imem_rdata;
      pp4_q   <= pc_plus4;
      valid_q <= 1'b1;
      if (count_q != 16'hFFFF)
        count_q <= count_q + 16'd1;
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc_plus4 = pp4_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: one kernel-reset and one user-reset instance driven
// with identical requests, checked against a behavioural model of the PC rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  pcsrc = 3'b000;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [25:0] jump_target = 26'h0;
  logic [31:0] jr_target = 32'h0;

  int total = 0;
  int passed = 0;
  int fails = 0;

  // Model state: index 0 = kernel-reset DUT, 1 = user-reset DUT.
  logic [31:0] m_pc[2];
  logic [31:0] m_instr[2];
  logic [31:0] m_pp4[2];
  logic        m_vld[2];
  logic [15:0] m_cnt[2];

  fetch_stage_if k_if ();
  fetch_stage_if u_if ();

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h2001_0000 + ((a >> 2) & 32'h0000_FFFF);
  endfunction

  assign k_if.stall = stall;          assign u_if.stall = stall;
  assign k_if.flush = flush;          assign u_if.flush = flush;
  assign k_if.pcsrc = pcsrc;          assign u_if.pcsrc = pcsrc;
  assign k_if.branch_taken = branch_taken;   assign u_if.branch_taken = branch_taken;
  assign k_if.branch_target = branch_target; assign u_if.branch_target = branch_target;
  assign k_if.jump_target = jump_target;     assign u_if.jump_target = jump_target;
  assign k_if.jr_target = jr_target;         assign u_if.jr_target = jr_target;
  assign k_if.imem_rdata = imem(k_if.imem_addr);
  assign u_if.imem_rdata = imem(u_if.imem_addr);

  fetch_stage dut_k (.clk(clk), .reset(reset), .bus(k_if.slave));
  fetch_stage #(.RESET_PC(32'h0000_0000)) dut_u (.clk(clk), .reset(reset), .bus(u_if.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc[0] = 32'h8000_0000;
    m_pc[1] = 32'h0000_0000;
    for (int d = 0; d < 2; d++) begin
      m_instr[d] = 32'h0; m_pp4[d] = 32'h0; m_vld[d] = 1'b0; m_cnt[d] = 16'h0;
    end
  endtask

  task automatic model_edge(input int d);
    logic [31:0] base, mode, p4, tgt;
    base = m_pc[d];
    mode = base & 32'h8000_0000;
    p4   = mode | ((base + 32'd4) & 32'h7FFF_FFFF);
    case (pcsrc)
      3'd1:    tgt = branch_taken ? (mode | (branch_target & 32'h7FFF_FFFF)) : p4;
      3'd2:    tgt = (p4 & 32'hF000_0000) | (32'(jump_target) * 4);
      3'd3:    tgt = mode | (jr_target & 32'h7FFF_FFFF);
      default: tgt = p4;
    endcase
    if (pcsrc == 3'd4 || pcsrc == 3'd5) begin
      m_pc[d] = (pcsrc == 3'd4) ? 32'h8000_0004 : 32'h8000_0008;
      m_instr[d] = 32'h0; m_pp4[d] = p4; m_vld[d] = 1'b0;
    end else if (stall) begin
      // frozen
    end else if (flush) begin
      m_pc[d] = tgt; m_instr[d] = 32'h0; m_pp4[d] = p4; m_vld[d] = 1'b0;
    end else begin
      m_pc[d] = tgt; m_instr[d] = imem(base); m_pp4[d] = p4; m_vld[d] = 1'b1;
      if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
    end
  endtask

  task automatic check_dut(input int d, input string tag);
    logic [31:0] a, i, p;
    logic v;
    logic [15:0] c;
    if (d == 0) begin
      a = k_if.imem_addr; i = k_if.ifid_instr; p = k_if.ifid_pc_plus4;
      v = k_if.ifid_valid; c = k_if.fetch_count;
    end else begin
      a = u_if.imem_addr; i = u_if.ifid_instr; p = u_if.ifid_pc_plus4;
      v = u_if.ifid_valid; c = u_if.fetch_count;
    end
    chk($sformatf("%s.d%0d.addr", tag, d), a, m_pc[d]);
    chk($sformatf("%s.d%0d.instr", tag, d), i, m_instr[d]);
    chk($sformatf("%s.d%0d.pp4", tag, d), p, m_pp4[d]);
    chk($sformatf("%s.d%0d.valid", tag, d), {31'b0, v}, {31'b0, m_vld[d]});
    chk($sformatf("%s.d%0d.count", tag, d), {16'b0, c}, {16'b0, m_cnt[d]});
  endtask

  task automatic tick(input string tag, input bit do_chk);
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    if (do_chk) begin
      check_dut(0, tag);
      check_dut(1, tag);
    end
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; pcsrc = 3'd0; branch_taken = 1'b0;
  endtask

  logic [15:0] saved_cnt;
  logic [31:0] saved_pc;

  initial begin
    // Reset state
    model_reset();
    #12;
    check_dut(0, "reset");
    check_dut(1, "reset");
    chk("reset.addr_const", k_if.imem_addr, 32'h8000_0000);
    reset = 1'b1;

    // Free running from reset
    tick("run1", 1'b1);
    chk("run1.addr", k_if.imem_addr, 32'h8000_0004);
    chk("run1.pp4", k_if.ifid_pc_plus4, 32'h8000_0004);
    chk("run1.instr", k_if.ifid_instr, 32'h2001_0000);
    chk("run1.valid", {31'b0, k_if.ifid_valid}, 32'd1);
    tick("run2", 1'b1);
    chk("run2.addr", k_if.imem_addr, 32'h8000_0008);
    chk("run2.pp4", k_if.ifid_pc_plus4, 32'h8000_0008);
    chk("run2.count", {16'b0, k_if.fetch_count}, 32'd2);
    tick("run3", 1'b1);

    // Advance the user-mode instance to 0x40, then stall two edges
    for (int n = 0; n < 13; n++) tick("adv", 1'b1);
    chk("adv.upc", u_if.imem_addr, 32'h0000_0040);
    saved_cnt = u_if.fetch_count;
    stall = 1'b1;
    tick("stall1", 1'b1);
    tick("stall2", 1'b1);
    chk("stall.upc", u_if.imem_addr, 32'h0000_0040);
    chk("stall.ucnt", {16'b0, u_if.fetch_count}, {16'b0, saved_cnt});
    idle();
    tick("unstall", 1'b1);
    chk("unstall.upc", u_if.imem_addr, 32'h0000_0044);

    // Jumps and jr keep the mode bit
    pcsrc = 3'd3; jr_target = 32'h0000_0100;
    tick("jr100", 1'b1);
    chk("jr100.kpc", k_if.imem_addr, 32'h8000_0100);
    pcsrc = 3'd2; jump_target = 26'h000_0040;
    tick("jmp", 1'b1);
    chk("jmp.upc", u_if.imem_addr, 32'h0000_0100);
    pcsrc = 3'd3; jr_target = 32'h8000_0200;
    tick("jr200", 1'b1);
    chk("jr200.upc", u_if.imem_addr, 32'h0000_0200);

    // Branch not taken, then taken with flush
    pcsrc = 3'd1; branch_taken = 1'b0; branch_target = 32'h0000_0080;
    tick("bnt", 1'b1);
    chk("bnt.upc", u_if.imem_addr, 32'h0000_0204);
    saved_cnt = u_if.fetch_count;
    branch_taken = 1'b1; flush = 1'b1;
    tick("bt", 1'b1);
    chk("bt.upc", u_if.imem_addr, 32'h0000_0080);
    chk("bt.instr", u_if.ifid_instr, 32'h0);
    chk("bt.valid", {31'b0, u_if.ifid_valid}, 32'd0);
    chk("bt.cnt", {16'b0, u_if.fetch_count}, {16'b0, saved_cnt});
    idle();

    // Exception overrides stall
    stall = 1'b1; pcsrc = 3'd5;
    tick("xadr", 1'b1);
    chk("xadr.upc", u_if.imem_addr, 32'h8000_0008);
    chk("xadr.valid", {31'b0, u_if.ifid_valid}, 32'd0);
    chk("xadr.pp4", u_if.ifid_pc_plus4, 32'h0000_0084);

    // Stall beats flush and a non-exception redirect
    saved_pc = k_if.imem_addr;
    stall = 1'b1; flush = 1'b1; pcsrc = 3'd2;
    tick("stfl", 1'b1);
    chk("stfl.kpc", k_if.imem_addr, saved_pc);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pcsrc         = 3'($urandom_range(0, 7));
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_taken  = 1'($urandom);
      branch_target = $urandom & 32'hFFFF_FFFC;
      jump_target   = 26'($urandom);
      jr_target     = $urandom & 32'hFFFF_FFFC;
      // keep exceptions rare so user mode survives a while
      if ((pcsrc == 3'd4 || pcsrc == 3'd5) && $urandom_range(0, 3) != 0) pcsrc = 3'd0;
      tick("rand", 1'b1);
    end

    // Async reset between edges while stall and flush are requested
    stall = 1'b1; flush = 1'b1; pcsrc = 3'd2;
    reset = 1'b0;
    model_reset();
    #1;
    check_dut(0, "areset");
    check_dut(1, "areset");
    #1 reset = 1'b1;
    idle();
    tick("post_reset", 1'b1);
    chk("post_reset.instr", k_if.ifid_instr, 32'h2001_0000);

    // Saturation of fetch_count
    for (int n = 0; n < 65540; n++) tick("sat", (m_cnt[0] >= 16'hFFFC));
    chk("sat.count", {16'b0, k_if.fetch_count}, 32'h0000_FFFF);
    tick("sat_hold", 1'b1);
    chk("sat_hold.count", {16'b0, u_if.fetch_count}, 32'h0000_FFFF);

    // Async reset mid-cycle clears saturated state
    reset = 1'b0;
    model_reset();
    #1;
    check_dut(0, "areset2");
    chk("areset2.count", {16'b0, k_if.fetch_count}, 32'h0);
    #1 reset = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
